// File: rtl/bin2bcd_if.sv
// bin2bcd_if: start/result bundle between a binary source and the bin2bcd_seq converter.
interface bin2bcd_if #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
);
    logic                  start;
    logic [WIDTH-1:0]      bin;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd;
    logic                  overflow;
    logic [DIGITS-1:0]     digit_blank;

    modport master (output start, bin, input busy, done, bcd, overflow, digit_blank);
    modport slave  (input start, bin, output busy, done, bcd, overflow, digit_blank);
endinterface

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential shift-and-add-3 binary to packed BCD, one bit per clock.
// Leading-zero blank mask generated only when BIN2BCD_BLANK_EN is defined.
module bin2bcd_seq #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic      clk,
    input  logic      rst_n,
    bin2bcd_if.slave  io
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t                state_q;
    logic [WIDTH-1:0]      bin_q, bin_d;
    logic [4*DIGITS-1:0]   dig_q, dig_d, adj_d, bcd_q;
    logic                  ovf_q, ovf_d, overflow_q, busy_q, done_q;
    logic [CW-1:0]         cnt_q;
    logic [DIGITS-1:0]     blank_q, blank_d;

    always_comb begin
        adj_d = dig_q;
        for (int i = 0; i < DIGITS; i++)
            if (dig_q[4*i +: 4] >= 4'd5) adj_d[4*i +: 4] = dig_q[4*i +: 4] + 4'd3;
        dig_d = {adj_d[4*DIGITS-2:0], bin_q[WIDTH-1]};
        bin_d = bin_q << 1;
        // a bit leaving the top digit is worth 10^DIGITS: dropping it keeps the result mod 10^DIGITS
        ovf_d = ovf_q | adj_d[4*DIGITS-1];
    end

`ifdef BIN2BCD_BLANK_EN
    always_comb begin
        blank_d = '0;
        for (int i = 1; i < DIGITS; i++)
            blank_d[i] = (dig_d >> (4*i)) == '0;
    end
`else
    assign blank_d = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            bin_q      <= '0;
            dig_q      <= '0;
            ovf_q      <= 1'b0;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            bcd_q      <= '0;
            overflow_q <= 1'b0;
            blank_q    <= '0;
        end else if (state_q == SHIFT) begin
            bin_q <= bin_d;
            dig_q <= dig_d;
            ovf_q <= ovf_d;
            cnt_q <= cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                state_q    <= DONE;
                busy_q     <= 1'b0;
                done_q     <= 1'b1;
                bcd_q      <= dig_d;
                overflow_q <= ovf_d;
                blank_q    <= blank_d;
            end
        end else begin
            state_q <= io.start ? SHIFT : IDLE;
            busy_q  <= io.start;
            done_q  <= 1'b0;
            if (io.start) begin
                bin_q <= io.bin;
                dig_q <= '0;
                ovf_q <= 1'b0;
                cnt_q <= CW'(WIDTH);
            end
        end
    end

    assign io.busy        = busy_q;
    assign io.done        = done_q;
    assign io.bcd         = bcd_q;
    assign io.overflow    = overflow_q;
    assign io.digit_blank = blank_q;
endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb_bin2bcd_seq: directed vectors on three converter configurations, scoreboarded on done.
module tb_bin2bcd_seq;
`ifdef BIN2BCD_BLANK_EN
    localparam bit BE = 1'b1;
`else
    localparam bit BE = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bin2bcd_if #(.WIDTH(8),  .DIGITS(3)) a();
    bin2bcd_if #(.WIDTH(16), .DIGITS(5)) b();
    bin2bcd_if #(.WIDTH(8),  .DIGITS(2)) c();

    bin2bcd_seq #(.WIDTH(8),  .DIGITS(3)) u_a (.clk(clk), .rst_n(rst_n), .io(a));
    bin2bcd_seq #(.WIDTH(16), .DIGITS(5)) u_b (.clk(clk), .rst_n(rst_n), .io(b));
    bin2bcd_seq #(.WIDTH(8),  .DIGITS(2)) u_c (.clk(clk), .rst_n(rst_n), .io(c));

    int checks = 0;
    int failures = 0;
    logic [31:0] qa[$], qb[$], qc[$];

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // expected entries are {overflow, digit_blank, bcd}
    always @(negedge clk) if (rst_n && a.done) begin
        if (qa.size() == 0) chk("a_unexpected_done", 32'(a.done), 32'd0);
        else chk("a_result", 32'({a.overflow, a.digit_blank, a.bcd}), qa.pop_front());
    end
    always @(negedge clk) if (rst_n && b.done) begin
        if (qb.size() == 0) chk("b_unexpected_done", 32'(b.done), 32'd0);
        else chk("b_result", 32'({b.overflow, b.digit_blank, b.bcd}), qb.pop_front());
    end
    always @(negedge clk) if (rst_n && c.done) begin
        if (qc.size() == 0) chk("c_unexpected_done", 32'(c.done), 32'd0);
        else chk("c_result", 32'({c.overflow, c.digit_blank, c.bcd}), qc.pop_front());
    end

    task automatic conv_a(logic [7:0] v, logic [11:0] e, logic ov, logic [2:0] bl);
        int n = 0;
        int nb;
        qa.push_back(32'({ov, BE ? bl : 3'b000, e}));
        @(negedge clk);
        a.start = 1'b1;
        a.bin = v;
        @(posedge clk); #1;
        a.start = 1'b0;
        nb = int'(a.busy);
        do begin
            @(posedge clk); #1;
            n++;
            nb += int'(a.busy);
        end while (!a.done && n < 40);
        chk("a_latency", 32'(n), 32'd8);
        chk("a_busy_cycles", 32'(nb), 32'd8);
    endtask

    task automatic conv_b(logic [15:0] v, logic [19:0] e, logic ov, logic [4:0] bl);
        int n = 0;
        qb.push_back(32'({ov, BE ? bl : 5'b00000, e}));
        @(negedge clk);
        b.start = 1'b1;
        b.bin = v;
        @(posedge clk); #1;
        b.start = 1'b0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!b.done && n < 60);
        chk("b_latency", 32'(n), 32'd16);
    endtask

    task automatic conv_c(logic [7:0] v, logic [7:0] e, logic ov, logic [1:0] bl);
        int n = 0;
        qc.push_back(32'({ov, BE ? bl : 2'b00, e}));
        @(negedge clk);
        c.start = 1'b1;
        c.bin = v;
        @(posedge clk); #1;
        c.start = 1'b0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!c.done && n < 40);
        chk("c_latency", 32'(n), 32'd8);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        time t1;
        a.start = 1'b0; a.bin = '0;
        b.start = 1'b0; b.bin = '0;
        c.start = 1'b0; c.bin = '0;
        #12;
        chk("reset_a", 32'({a.busy, a.done, a.overflow, a.digit_blank, a.bcd}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        conv_a(8'd255, 12'h255, 1'b0, 3'b000);
        conv_a(8'd0,   12'h000, 1'b0, 3'b110);
        conv_a(8'd9,   12'h009, 1'b0, 3'b110);
        conv_a(8'd100, 12'h100, 1'b0, 3'b000);
        conv_a(8'd7,   12'h007, 1'b0, 3'b110);
        conv_a(8'd105, 12'h105, 1'b0, 3'b000);

        conv_b(16'd65535, 20'h65535, 1'b0, 5'b00000);
        conv_b(16'd10000, 20'h10000, 1'b0, 5'b00000);
        conv_b(16'd5,     20'h00005, 1'b0, 5'b11110);

        conv_c(8'd200, 8'h00, 1'b1, 2'b10);
        conv_c(8'd99,  8'h99, 1'b0, 2'b00);

        // start held through the whole conversion with bin wandering: only 17 converts
        repeat (2) @(posedge clk);
        qa.push_back(32'({1'b0, BE ? 3'b100 : 3'b000, 12'h017}));
        @(negedge clk);
        a.start = 1'b1;
        a.bin = 8'd17;
        @(posedge clk); #1;
        chk("a_hold_busy", 32'(a.busy), 32'd1);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            a.bin = 8'(200 + i);
            @(posedge clk); #1;
        end
        a.start = 1'b0;
        chk("a_hold_done", 32'(a.done), 32'd1);
        @(posedge clk); #1;
        chk("a_hold_no_restart", 32'({a.busy, a.done}), 32'd0);

        // back-to-back: start during the done cycle
        conv_a(8'd9, 12'h009, 1'b0, 3'b110);
        t1 = $time;
        conv_a(8'd42, 12'h042, 1'b0, 3'b100);
        chk("a_b2b_gap", 32'(($time - t1) / 10), 32'd9);

        // reset in the third SHIFT cycle discards the conversion
        @(negedge clk);
        a.start = 1'b1;
        a.bin = 8'd123;
        @(posedge clk); #1;
        a.start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("a_reset_mid", 32'({a.busy, a.done, a.overflow, a.digit_blank, a.bcd}), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        conv_a(8'd100, 12'h100, 1'b0, 3'b000);

        repeat (3) @(posedge clk);
        chk("queues_empty", 32'(qa.size() + qb.size() + qc.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
